// File: rtl/vga_line_fetcher_pkg.sv
// Shared VGA/display constants and the line fetcher FSM encoding.
package vga_line_fetcher_pkg;

    localparam int VC_W      = 10;
    localparam int DATA_W    = 16;
    localparam int V_TOTAL   = 525;
    localparam int V_VISIBLE = 480;

    localparam int               DEF_ADDR_W     = 16;
    localparam int               DEF_CELL_SHIFT = 4;
    localparam int               DEF_BOARD_ROWS = 30;
    localparam logic [15:0]      DEF_BASE_ADDR  = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vga_line_fetcher_if.sv
// Read port to the shared game memory: held request, one-cycle grant, later data strobe.
interface vga_line_fetcher_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/vga_line_fetcher_line_change_detect.sv
// Tracks vcount changes and flags the prefetch trigger (last line of a cell row) and row swap.
module vga_line_fetcher_line_change_detect
    import vga_line_fetcher_pkg::*;
#(
    parameter int CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int LINES      = V_TOTAL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [VC_W-1:0] vcount,
    output logic            trigger,
    output logic            swap,
    output logic [VC_W-1:0] target_row
);

    localparam logic [VC_W-1:0]       LAST_LINE = VC_W'(LINES - 1);
    localparam logic [CELL_SHIFT-1:0] LOW_ONES  = '1;

    logic [VC_W-1:0] vcount_q;
    logic [VC_W-1:0] next_line;
    logic            line_chg;

    always_ff @(posedge clk) begin
        if (!reset) vcount_q <= '0;
        else        vcount_q <= vcount;
    end

    // The frame's last line also triggers so row 0 is ready when vcount wraps.
    always_comb begin
        line_chg   = (vcount != vcount_q);
        trigger    = line_chg && ((vcount[CELL_SHIFT-1:0] == LOW_ONES) || (vcount == LAST_LINE));
        swap       = line_chg && (vcount[CELL_SHIFT-1:0] == '0);
        next_line  = (vcount == LAST_LINE) ? '0 : vcount + VC_W'(1);
        target_row = next_line >> CELL_SHIFT;
    end

endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches the next board row from game memory and double-buffers it for the VGA bit generator.
module vga_line_fetcher
    import vga_line_fetcher_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int                CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int                BOARD_ROWS = DEF_BOARD_ROWS,
    parameter int                LINES      = V_TOTAL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VC_W-1:0]     vcount,
    vga_line_fetcher_if.master  mem,
    output logic [DATA_W-1:0]   curr_line,
    output logic                underrun
);

    fetch_state_t      state, state_nxt;
    logic              trigger, swap;
    logic [VC_W-1:0]   target_row;
    logic [VC_W-1:0]   tgt_row_q;
    logic              req_pend, discard;
    logic [DATA_W-1:0] pending;
    logic              pending_valid;
    logic              in_range, fetch_trig, launch, rd_done, rd_keep;

    vga_line_fetcher_line_change_detect #(
        .CELL_SHIFT (CELL_SHIFT),
        .LINES      (LINES)
    ) u_detect (
        .clk        (clk),
        .reset      (reset),
        .vcount     (vcount),
        .trigger    (trigger),
        .swap       (swap),
        .target_row (target_row)
    );

    always_comb begin
        in_range   = (target_row < VC_W'(BOARD_ROWS));
        fetch_trig = trigger && in_range;
        launch     = (state == ST_IDLE) && (fetch_trig || req_pend);
        rd_done    = (state == ST_WAIT) && mem.mem_rvalid;
        // Data returning in the same cycle as a new trigger is already stale.
        rd_keep    = rd_done && !discard && !trigger;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch)             state_nxt = ST_REQ;
            ST_REQ:  if (mem.mem_gnt)        state_nxt = ST_WAIT;
            ST_WAIT: if (mem.mem_rvalid)     state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req = (state == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem.mem_addr  <= '0;
            tgt_row_q     <= '0;
            req_pend      <= 1'b0;
            discard       <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            curr_line     <= '0;
            underrun      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (swap) begin
                curr_line     <= pending_valid ? pending : '0;
                underrun      <= !pending_valid;
                pending_valid <= 1'b0;
            end
            // Rows past the board need no fetch: a blank row is ready immediately.
            if (trigger) begin
                if (!in_range) begin
                    pending       <= '0;
                    pending_valid <= 1'b1;
                    req_pend      <= 1'b0;
                end else begin
                    pending_valid <= 1'b0;
                    tgt_row_q     <= target_row;
                    req_pend      <= (state != ST_IDLE);
                end
                if (state != ST_IDLE) discard <= 1'b1;
            end
            if (launch) begin
                mem.mem_addr <= BASE_ADDR + ADDR_W'(fetch_trig ? target_row : tgt_row_q);
                if (!fetch_trig) req_pend <= 1'b0;
            end
            if (rd_done) discard <= 1'b0;
            if (rd_keep) begin
                pending       <= mem.mem_rdata;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule
